vending_controller: RTL and testbench

- Vending transaction controller directly downstream of the coin counter stage.
- Consumes single-cycle coin events (values 1, 2, 5) and product selections, and owns the credit register.
- Drives the dispense strobe and returns change one coin at a time through a valid/ack handshake.
- Exports the binary credit value (0..99) to the decimal converter / seven-segment display stage.

---
 rtl/vending_if.sv | 32 +++
 rtl/vending_controller.sv | 142 ++++++++++++++
 tb/tb_vending_controller.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vending_if.sv
// Transaction-side signals of the vending controller: coin/selection/cancel
// events in, credit, pulses, dispense and change handshake out.
interface vending_if;
    logic       coin_valid;
    logic [2:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       cancel;
    logic       change_ack;
    logic [6:0] credit;
    logic       coin_reject;
    logic       insufficient;
    logic       dispense;
    logic [1:0] dispense_item;
    logic       change_valid;
    logic [2:0] change_coin;
    logic       busy;

    // Upstream side: coin counter, keypad and coin ejector.
    modport master (
        output coin_valid, coin_value, sel_valid, sel_item, cancel, change_ack,
        input  credit, coin_reject, insufficient, dispense, dispense_item,
               change_valid, change_coin, busy
    );

    // Controller side.
    modport slave (
        input  coin_valid, coin_value, sel_valid, sel_item, cancel, change_ack,
        output credit, coin_reject, insufficient, dispense, dispense_item,
               change_valid, change_coin, busy
    );
endinterface

// File: rtl/vending_controller.sv
// Vending transaction controller: owns the credit register, dispenses the
// selected item and pays change back one coin at a time.
module vending_controller #(
    parameter int unsigned PRICE0          = 3,
    parameter int unsigned PRICE1          = 7,
    parameter int unsigned PRICE2          = 10,
    parameter int unsigned PRICE3          = 15,
    parameter int unsigned MAX_CREDIT      = 99,
    parameter int unsigned DISPENSE_CYCLES = 4
) (
    input logic     clock,
    input logic     reset_n,
    vending_if.slave bus
);
    localparam int unsigned CntW = $clog2(DISPENSE_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StCredit, StDispense, StChange} state_e;

    state_e          state_q;
    logic [6:0]      credit_q;
    logic [CntW-1:0] dcnt_q;
    logic [1:0]      dispense_item_q;
    logic            dispense_q;
    logic            coin_reject_q;
    logic            insufficient_q;
    logic            busy_q;

    logic [6:0] price;
    logic [7:0] coin_sum;
    logic       coin_ok;
    logic [2:0] change_coin;
    logic [6:0] change_left;

    always_comb begin
        price = 7'(PRICE0);
        unique case (bus.sel_item)
            2'd0: price = 7'(PRICE0);
            2'd1: price = 7'(PRICE1);
            2'd2: price = 7'(PRICE2);
            2'd3: price = 7'(PRICE3);
            default: price = 7'(PRICE0);
        endcase
    end

    // 8-bit sum so the MAX_CREDIT check cannot wrap.
    assign coin_sum = {1'b0, credit_q} + {5'b0, bus.coin_value};
    assign coin_ok  = (bus.coin_value == 3'd1 || bus.coin_value == 3'd2 ||
                       bus.coin_value == 3'd5) && (coin_sum <= 8'(MAX_CREDIT));

    always_comb begin
        change_coin = 3'd0;
        if (state_q == StChange) begin
            if (credit_q >= 7'd5)      change_coin = 3'd5;
            else if (credit_q >= 7'd2) change_coin = 3'd2;
            else                       change_coin = 3'd1;
        end
    end

    assign change_left = credit_q - {4'b0, change_coin};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            credit_q        <= '0;
            dcnt_q          <= '0;
            dispense_item_q <= '0;
            dispense_q      <= 1'b0;
            coin_reject_q   <= 1'b0;
            insufficient_q  <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            case (state_q)
                StIdle, StCredit: begin
                    if (bus.cancel && state_q == StCredit) begin
                        state_q       <= StChange;
                        busy_q        <= 1'b1;
                        coin_reject_q <= bus.coin_valid;
                    end else if (bus.sel_valid) begin
                        coin_reject_q <= bus.coin_valid;
                        // A zero price is affordable even from IDLE.
                        if (credit_q >= price) begin
                            credit_q        <= credit_q - price;
                            dispense_item_q <= bus.sel_item;
                            dispense_q      <= 1'b1;
                            dcnt_q          <= CntW'(DISPENSE_CYCLES - 1);
                            busy_q          <= 1'b1;
                            state_q         <= StDispense;
                        end else begin
                            insufficient_q <= 1'b1;
                        end
                    end else if (bus.coin_valid) begin
                        if (coin_ok) begin
                            credit_q <= coin_sum[6:0];
                            state_q  <= StCredit;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end
                end
                StDispense: begin
                    coin_reject_q <= bus.coin_valid;
                    if (dcnt_q == '0) begin
                        dispense_q <= 1'b0;
                        if (credit_q != '0) begin
                            state_q <= StChange;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        dcnt_q <= dcnt_q - 1'b1;
                    end
                end
                StChange: begin
                    coin_reject_q <= bus.coin_valid;
                    if (bus.change_ack) begin
                        credit_q <= change_left;
                        if (change_left == '0) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.credit        = credit_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.insufficient  = insufficient_q;
    assign bus.dispense      = dispense_q;
    assign bus.dispense_item = dispense_item_q;
    assign bus.change_valid  = (state_q == StChange);
    assign bus.change_coin   = change_coin;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_vending_controller.sv
// Directed self-checking bench for vending_controller with default prices
// 3/7/10/15, MAX_CREDIT 99 and DISPENSE_CYCLES 4.
module tb_vending_controller;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    vending_if bus ();

    vending_controller dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [2:0] v);
        bus.coin_valid = 1'b1;
        bus.coin_value = v;
        tick();
        bus.coin_valid = 1'b0;
        bus.coin_value = 3'd0;
    endtask

    task automatic select(input logic [1:0] item);
        bus.sel_valid = 1'b1;
        bus.sel_item  = item;
        tick();
        bus.sel_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " credit"}, 32'(bus.credit), 0);
        chk({tag, " dispense"}, 32'(bus.dispense), 0);
        chk({tag, " dispense_item"}, 32'(bus.dispense_item), 0);
        chk({tag, " change_valid"}, 32'(bus.change_valid), 0);
        chk({tag, " change_coin"}, 32'(bus.change_coin), 0);
        chk({tag, " busy"}, 32'(bus.busy), 0);
        chk({tag, " coin_reject"}, 32'(bus.coin_reject), 0);
        chk({tag, " insufficient"}, 32'(bus.insufficient), 0);
    endtask

    initial begin
        logic [2:0] exp_coin [4];
        exp_coin[0] = 3'd5;
        exp_coin[1] = 3'd5;
        exp_coin[2] = 3'd2;
        exp_coin[3] = 3'd1;

        bus.coin_valid = 1'b0;
        bus.coin_value = 3'd0;
        bus.sel_valid  = 1'b0;
        bus.sel_item   = 2'd0;
        bus.cancel     = 1'b0;
        bus.change_ack = 1'b0;

        // Reset
        tick();
        tick();
        chk_reset_state("reset");
        reset_n = 1'b1;

        // Coins 5, 2, 1
        coin(3'd5);
        chk("coin5 credit", 32'(bus.credit), 5);
        chk("coin5 reject", 32'(bus.coin_reject), 0);
        coin(3'd2);
        chk("coin2 credit", 32'(bus.credit), 7);
        coin(3'd1);
        chk("coin1 credit", 32'(bus.credit), 8);
        chk("coin1 reject", 32'(bus.coin_reject), 0);
        chk("credit busy", 32'(bus.busy), 0);

        // Buy item 1 (price 7) with credit 8
        select(2'd1);
        chk("buy credit", 32'(bus.credit), 1);
        chk("buy item", 32'(bus.dispense_item), 1);
        chk("buy busy", 32'(bus.busy), 1);
        for (int i = 0; i < 4; i++) begin
            chk("dispense high", 32'(bus.dispense), 1);
            chk("dispense no change", 32'(bus.change_valid), 0);
            tick();
        end
        chk("dispense done", 32'(bus.dispense), 0);
        chk("change1 valid", 32'(bus.change_valid), 1);
        chk("change1 coin", 32'(bus.change_coin), 1);
        bus.change_ack = 1'b1;
        tick();
        bus.change_ack = 1'b0;
        chk("change1 credit", 32'(bus.credit), 0);
        chk("change1 valid off", 32'(bus.change_valid), 0);
        chk("change1 idle", 32'(bus.busy), 0);

        // Insufficient credit and illegal coin
        coin(3'd2);
        coin(3'd2);
        chk("credit4", 32'(bus.credit), 4);
        select(2'd1);
        chk("insuff pulse", 32'(bus.insufficient), 1);
        chk("insuff credit", 32'(bus.credit), 4);
        chk("insuff no dispense", 32'(bus.dispense), 0);
        tick();
        chk("insuff one cycle", 32'(bus.insufficient), 0);
        coin(3'd3);
        chk("coin3 reject", 32'(bus.coin_reject), 1);
        chk("coin3 credit", 32'(bus.credit), 4);
        tick();
        chk("coin3 reject one cycle", 32'(bus.coin_reject), 0);

        // Climb to 97, then MAX_CREDIT boundary
        for (int i = 0; i < 18; i++) coin(3'd5);
        coin(3'd2);
        coin(3'd1);
        chk("credit97", 32'(bus.credit), 97);
        coin(3'd5);
        chk("over max reject", 32'(bus.coin_reject), 1);
        chk("over max credit", 32'(bus.credit), 97);
        coin(3'd2);
        chk("to 99 credit", 32'(bus.credit), 99);
        chk("to 99 reject", 32'(bus.coin_reject), 0);
        coin(3'd1);
        chk("at max reject", 32'(bus.coin_reject), 1);
        chk("at max credit", 32'(bus.credit), 99);

        // Coin together with an accepted selection (item 3, price 15)
        bus.coin_valid = 1'b1;
        bus.coin_value = 3'd2;
        select(2'd3);
        bus.coin_valid = 1'b0;
        chk("sel+coin reject", 32'(bus.coin_reject), 1);
        chk("sel+coin credit", 32'(bus.credit), 84);
        chk("sel+coin dispense", 32'(bus.dispense), 1);
        chk("sel+coin item", 32'(bus.dispense_item), 3);
        tick();

        // Reset mid-DISPENSE
        chk("pre-reset dispense", 32'(bus.dispense), 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset_state("rst dispense");
        coin(3'd2);
        chk("post rst coin2", 32'(bus.credit), 2);

        // Credit 13, cancel, slow ack
        coin(3'd5);
        coin(3'd5);
        coin(3'd1);
        chk("credit13", 32'(bus.credit), 13);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 3; w++) begin
                chk("change wait valid", 32'(bus.change_valid), 1);
                chk("change wait coin", 32'(bus.change_coin), 32'(exp_coin[k]));
                tick();
            end
            bus.change_ack = 1'b1;
            tick();
            bus.change_ack = 1'b0;
        end
        chk("refund credit", 32'(bus.credit), 0);
        chk("refund valid off", 32'(bus.change_valid), 0);
        chk("refund idle", 32'(bus.busy), 0);

        // Coin with accepted cancel, then reset mid-CHANGE at credit 8
        coin(3'd5);
        coin(3'd2);
        coin(3'd1);
        chk("credit8", 32'(bus.credit), 8);
        bus.cancel     = 1'b1;
        bus.coin_valid = 1'b1;
        bus.coin_value = 3'd1;
        tick();
        bus.cancel     = 1'b0;
        bus.coin_valid = 1'b0;
        chk("cancel+coin reject", 32'(bus.coin_reject), 1);
        chk("cancel+coin credit", 32'(bus.credit), 8);
        chk("cancel change coin", 32'(bus.change_coin), 5);
        coin(3'd2);
        chk("change coin reject", 32'(bus.coin_reject), 1);
        chk("change coin credit", 32'(bus.credit), 8);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk_reset_state("rst change");
        coin(3'd2);
        chk("post rst2 coin2", 32'(bus.credit), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
